// File: rtl/slot_sensor_scanner_pkg.sv
// Shared definitions for the slot sensor scanner: scan FSM encoding,
// matrix geometry and the column strobe pattern driven in each state.
package slot_sensor_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COL0 = 2'd1,
    ST_COL1 = 2'd2
  } scan_state_t;

  localparam int NUM_COLS  = 2;
  localparam int NUM_ROWS  = 4;
  localparam int NUM_SLOTS = NUM_COLS * NUM_ROWS;

  // Column strobes are active-low; idle drives no column.
  localparam logic [1:0] COL_DRV_IDLE = 2'b11;
  localparam logic [1:0] COL_DRV_0    = 2'b10;
  localparam logic [1:0] COL_DRV_1    = 2'b01;

  function automatic logic [1:0] col_drive_for(input scan_state_t s);
    case (s)
      ST_COL0: col_drive_for = COL_DRV_0;
      ST_COL1: col_drive_for = COL_DRV_1;
      default: col_drive_for = COL_DRV_IDLE;
    endcase
  endfunction

  function automatic logic [3:0] slot_popcount(input logic [NUM_SLOTS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/slot_sensor_scanner_slot_debounce.sv
// Single-slot debouncer: a stable occupancy bit that flips only after
// DEBOUNCE_SAMPLES consecutive samples disagree with it.
module slot_debounce
  import slot_sensor_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic sample,
  output logic stable,
  output logic toggle
);

  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0] LAST_DISAGREE = CW'(DEBOUNCE_SAMPLES - 1);

  logic [CW-1:0] agree_cnt;
  logic [CW-1:0] agree_cnt_nxt;

  // Count consecutive disagreeing samples; an agreeing sample restarts the run.
  always_comb begin
    agree_cnt_nxt = agree_cnt;
    toggle        = 1'b0;
    if (sample_en) begin
      if (sample == stable) begin
        agree_cnt_nxt = '0;
      end else if (agree_cnt == LAST_DISAGREE) begin
        agree_cnt_nxt = '0;
        toggle        = 1'b1;
      end else begin
        agree_cnt_nxt = agree_cnt + 1'b1;
      end
    end
  end

  // Hold the run length and the debounced bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agree_cnt <= '0;
      stable    <= 1'b0;
    end else begin
      agree_cnt <= agree_cnt_nxt;
      stable    <= stable ^ toggle;
    end
  end

endmodule

// File: rtl/slot_sensor_scanner.sv
// Slot sensor scanner: strobes a 2x4 active-low sensor matrix one column at
// a time, synchronises the row lines, debounces every slot and publishes a
// clean occupancy vector with valid/changed qualifiers.
// Optional feature: define SLOT_COUNT_EN to add registered num_on/num_off
// occupancy counts alongside ch.
module slot_sensor_scanner
  import slot_sensor_scanner_pkg::*;
#(
  parameter int SCAN_DIV         = 8,
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input  logic       clk_internal,
  input  logic       rst_n,
  input  logic [3:0] row_sense,
  output logic [1:0] col_drive,
  output logic [7:0] ch,
  output logic       ch_valid,
  output logic       ch_changed
`ifdef SLOT_COUNT_EN
  ,
  output logic [3:0] num_on,
  output logic [3:0] num_off
`endif
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FRM_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_DWELL = CNT_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_FULL   = FRM_W'(DEBOUNCE_SAMPLES);

  logic [NUM_ROWS-1:0]  row_s1;
  logic [NUM_ROWS-1:0]  row_s2;
  scan_state_t          state;
  scan_state_t          state_nxt;
  logic [CNT_W-1:0]     dwell;
  logic [CNT_W-1:0]     dwell_nxt;
  logic                 last_dwell;
  logic                 col1_done;
  logic [NUM_SLOTS-1:0] slot_en;
  logic [NUM_SLOTS-1:0] slot_tgl;
  logic [FRM_W-1:0]     frame_cnt;

  // Two-flop synchroniser for the asynchronous row lines; idle rows read high.
  always_ff @(posedge clk_internal or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_sense;
      row_s2 <= row_s1;
    end
  end

  // Scan state, dwell counter and the registered column strobes.
  always_ff @(posedge clk_internal or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dwell     <= '0;
      col_drive <= COL_DRV_IDLE;
    end else begin
      state     <= state_nxt;
      dwell     <= dwell_nxt;
      col_drive <= col_drive_for(state_nxt);
    end
  end

  // Next-state: leave idle at once, then alternate columns after each full dwell.
  always_comb begin
    state_nxt  = state;
    dwell_nxt  = dwell;
    last_dwell = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_COL0;
        dwell_nxt = '0;
      end
      ST_COL0: begin
        if (dwell == LAST_DWELL) begin
          last_dwell = 1'b1;
          state_nxt  = ST_COL1;
          dwell_nxt  = '0;
        end else begin
          dwell_nxt = dwell + 1'b1;
        end
      end
      ST_COL1: begin
        if (dwell == LAST_DWELL) begin
          last_dwell = 1'b1;
          state_nxt  = ST_COL0;
          dwell_nxt  = '0;
        end else begin
          dwell_nxt = dwell + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        dwell_nxt = '0;
      end
    endcase
  end

  assign col1_done = last_dwell && (state == ST_COL1);

  // Slot i sits at column i/NUM_ROWS, row i%NUM_ROWS; it samples on the
  // last dwell cycle of its own column, by which time the rows have settled.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    localparam int COL = i / NUM_ROWS;
    localparam int ROW = i % NUM_ROWS;

    assign slot_en[i] = last_dwell && ((state == ST_COL1) == (COL == NUM_COLS - 1));

    slot_debounce #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_slot (
      .clk      (clk_internal),
      .rst_n    (rst_n),
      .sample_en(slot_en[i]),
      .sample   (~row_s2[ROW]),
      .stable   (ch[i]),
      .toggle   (slot_tgl[i])
    );
  end

  // One change pulse per update cycle, coincident with the new ch value.
  always_ff @(posedge clk_internal or negedge rst_n) begin
    if (!rst_n) begin
      ch_changed <= 1'b0;
    end else begin
      ch_changed <= |slot_tgl;
    end
  end

  // Count completed COL1 samples until every slot has its full sample history.
  always_ff @(posedge clk_internal or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      ch_valid  <= 1'b0;
    end else begin
      if (col1_done && (frame_cnt != FRM_FULL)) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (col1_done && (frame_cnt == FRM_FULL - 1'b1)) begin
        ch_valid <= 1'b1;
      end
    end
  end

`ifdef SLOT_COUNT_EN
  logic [NUM_SLOTS-1:0] ch_nxt;
  logic [3:0]           on_nxt;

  assign ch_nxt = ch ^ slot_tgl;
  assign on_nxt = slot_popcount(ch_nxt);

  // Occupancy counts track the value ch is about to take, so both move together.
  always_ff @(posedge clk_internal or negedge rst_n) begin
    if (!rst_n) begin
      num_on  <= 4'd0;
      num_off <= 4'd8;
    end else begin
      num_on  <= on_nxt;
      num_off <= 4'(NUM_SLOTS) - on_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_slot_sensor_scanner.sv
// Bench for slot_sensor_scanner: a sensor-matrix stimulus, a cycle-level
// model of scan schedule and debounce, and directed literal checkpoints.
module tb_slot_sensor_scanner;

  localparam int SD = 8;
  localparam int DS = 3;

  logic       clk_internal = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] row_sense;
  logic [1:0] col_drive;
  logic [7:0] ch;
  logic       ch_valid;
  logic       ch_changed;
`ifdef SLOT_COUNT_EN
  logic [3:0] num_on;
  logic [3:0] num_off;
`endif

  // Which slots have a car parked: bit 4*col+row.
  logic [7:0] press = 8'h00;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  // Model state
  int         m_e = 0;
  logic [7:0] m_ch = 8'h00;
  int         m_cnt[8];
  logic       m_changed = 1'b0;
  logic       m_valid = 1'b0;
  int         m_frames = 0;
  logic [3:0] h1 = 4'hF;
  logic [3:0] h2 = 4'hF;
  logic [3:0] row_q = 4'hF;
  logic [3:0] smp;
  int         mcol;
  int         mslot;
  logic [1:0] exp_col;

  slot_sensor_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SAMPLES(DS)
  ) dut (
    .clk_internal(clk_internal),
    .rst_n       (rst_n),
    .row_sense   (row_sense),
    .col_drive   (col_drive),
    .ch          (ch),
    .ch_valid    (ch_valid),
    .ch_changed  (ch_changed)
`ifdef SLOT_COUNT_EN
    ,
    .num_on      (num_on),
    .num_off     (num_off)
`endif
  );

  always #10 clk_internal = ~clk_internal;

  // Passive matrix: a pressed sensor pulls its row low while its column is driven.
  always_comb begin
    row_sense = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_sense[r] = ~((~col_drive[0] & press[r]) | (~col_drive[1] & press[4 + r]));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_internal);
    #2;
  endtask

  // Model: edge e after release; columns alternate every SD edges starting with
  // col0 at e=1; each column is sampled on its last dwell edge, using the row
  // level seen two edges earlier.
  initial begin
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    forever begin
      @(posedge clk_internal);
      if (!rst_n) begin
        m_e = 0;
        m_ch = 8'h00;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_changed = 1'b0;
        m_valid = 1'b0;
        m_frames = 0;
        h1 = 4'hF;
        h2 = 4'hF;
      end else begin
        smp = h2;
        m_e++;
        m_changed = 1'b0;
        if (m_e > SD && ((m_e - 1) % SD) == 0) begin
          mcol = ((m_e - 2) / SD) % 2;
          for (int r = 0; r < 4; r++) begin
            mslot = 4 * mcol + r;
            if (~smp[r] == m_ch[mslot]) begin
              m_cnt[mslot] = 0;
            end else begin
              m_cnt[mslot]++;
              if (m_cnt[mslot] == DS) begin
                m_ch[mslot] = ~m_ch[mslot];
                m_cnt[mslot] = 0;
                m_changed = 1'b1;
              end
            end
          end
          if (mcol == 1 && m_frames < DS) m_frames++;
        end
        m_valid = (m_frames == DS);
        h2 = h1;
        h1 = row_q;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk_internal);
      row_q = row_sense;
      if (ch_changed === 1'b1) pulses++;
      if (!rst_n) begin
        check("rst col_drive", 32'(col_drive), 32'(2'b11));
        check("rst ch", 32'(ch), 32'h00);
        check("rst ch_valid", 32'(ch_valid), 32'h0);
        check("rst ch_changed", 32'(ch_changed), 32'h0);
`ifdef SLOT_COUNT_EN
        check("rst num_on", 32'(num_on), 32'd0);
        check("rst num_off", 32'(num_off), 32'd8);
`endif
      end else begin
        if (m_e == 0) exp_col = 2'b11;
        else if ((((m_e - 1) / SD) % 2) == 1) exp_col = 2'b01;
        else exp_col = 2'b10;
        check("model col_drive", 32'(col_drive), 32'(exp_col));
        check("model ch", 32'(ch), 32'(m_ch));
        check("model ch_valid", 32'(ch_valid), 32'(m_valid));
        check("model ch_changed", 32'(ch_changed), 32'(m_changed));
`ifdef SLOT_COUNT_EN
        check("model num_on", 32'(num_on), 32'($countones(m_ch)));
        check("model num_off", 32'(num_off), 32'(8 - $countones(m_ch)));
`endif
      end
    end
  end

  // Directed sequence with literal checkpoints.
  initial begin
    #1 rst_n = 1'b0;
    press = 8'h00;
    step(3);
    check("reset col_drive", 32'(col_drive), 32'(2'b11));
    check("reset ch", 32'(ch), 32'h00);
    rst_n = 1'b1;

    // Scan start-up and valid timing
    step(1);
    check("first col0", 32'(col_drive), 32'(2'b10));
    step(8);
    check("first col1", 32'(col_drive), 32'(2'b01));
    step(39);
    check("valid before 3rd col1", 32'(ch_valid), 32'h0);
    step(1);
    check("valid at 3rd col1", 32'(ch_valid), 32'h1);
    check("idle ch", 32'(ch), 32'h00);
    check("idle pulses", 32'(pulses), 32'd0);

    // Row 2 held low on column 0
    press = 8'h04;
    step(56);
    check("col0 row2 ch", 32'(ch), 32'h04);
    check("col0 row2 pulses", 32'(pulses), 32'd1);
    press = 8'h00;
    step(56);
    check("col0 row2 release ch", 32'(ch), 32'h00);
    check("col0 row2 release pulses", 32'(pulses), 32'd2);

    // Short glitch on column 1 row 1 (at most two samples)
    press = 8'h20;
    step(20);
    press = 8'h00;
    step(40);
    check("glitch ch", 32'(ch), 32'h00);
    check("glitch pulses", 32'(pulses), 32'd2);
    check("valid stays", 32'(ch_valid), 32'h1);

    // Everything occupied
    press = 8'hFF;
    step(64);
    check("all ch", 32'(ch), 32'hFF);
    check("all pulses", 32'(pulses), 32'd4);
`ifdef SLOT_COUNT_EN
    check("all num_on", 32'(num_on), 32'd8);
    check("all num_off", 32'(num_off), 32'd0);
`endif
    press = 8'h00;
    step(64);
    check("all release ch", 32'(ch), 32'h00);
    check("all release pulses", 32'(pulses), 32'd6);

    // Reset in the middle of a debounce run
    press = 8'h0F;
    step(64);
    check("col0 full ch", 32'(ch), 32'h0F);
    press = 8'hF0;
    step(20);
    check("mid debounce ch", 32'(ch), 32'h0F);
    rst_n = 1'b0;
    #1;
    check("async rst col_drive", 32'(col_drive), 32'(2'b11));
    check("async rst ch", 32'(ch), 32'h00);
    check("async rst valid", 32'(ch_valid), 32'h0);
    check("async rst changed", 32'(ch_changed), 32'h0);
`ifdef SLOT_COUNT_EN
    check("async rst num_on", 32'(num_on), 32'd0);
    check("async rst num_off", 32'(num_off), 32'd8);
`endif
    step(3);
    press = 8'h0F;
    rst_n = 1'b1;
    step(64);
    check("rebuild ch", 32'(ch), 32'h0F);
    check("rebuild valid", 32'(ch_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
